// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: datapath width, reset vector,
// sequential PC step and the encoding used for a pipeline bubble.
package mips_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam int          PC_INC     = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: instruction, PC+increment and valid flag.
// Flush has priority over write-enable; with neither, the register holds.
module ifid_pipe_reg
  import mips_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_en,
  input  logic         flush_n,
  input  logic [W-1:0] instr_d,
  input  logic [W-1:0] pc_plus4_d,
  output logic [W-1:0] instr_q,
  output logic [W-1:0] pc_plus4_q,
  output logic         valid_q
);

  localparam logic [W-1:0] BUBBLE = W'(NOP_INSTR);

  // Load a bubble on flush, the fetched word on write, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= BUBBLE;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!flush_n) begin
      instr_q    <= BUBBLE;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (write_en) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage_pc_ifid.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds stall and flush event counters
// (stall_cnt_o, flush_cnt_o); without it those ports do not exist.
module if_stage_pc_ifid #(
  parameter int                    DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int                    PC_INC     = mips_pkg::PC_INC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write_i,
  input  logic                  ifid_write_i,
  input  logic                  ifid_flush_n_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] jump_target_i,
  input  logic                  jr_i,
  input  logic [DATA_WIDTH-1:0] jr_target_i,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ifid_instr_o,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
`endif
  output logic                  ifid_valid_o
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(PC_INC);

  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus_inc;

  assign pc_plus_inc = pc_reg + PC_STEP;

  // Redirect priority: jr, then jump, then taken branch, else sequential.
  always_comb begin
    pc_next = pc_plus_inc;
    if (jr_i)                pc_next = jr_target_i;
    else if (jump_i)         pc_next = jump_target_i;
    else if (branch_taken_i) pc_next = branch_target_i;
  end

  // PC advances only when the hazard unit allows it; a stall also blocks redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc_reg <= RESET_PC;
    else if (pc_write_i) pc_reg <= pc_next;
  end

  assign pc_o        = pc_reg;
  assign imem_addr_o = pc_reg;

  ifid_pipe_reg #(
    .W (DATA_WIDTH)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .write_en   (ifid_write_i),
    .flush_n    (ifid_flush_n_i),
    .instr_d    (imem_instr_i),
    .pc_plus4_d (pc_plus_inc),
    .instr_q    (ifid_instr_o),
    .pc_plus4_q (ifid_pc_plus4_o),
    .valid_q    (ifid_valid_o)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Count stalled and flushed edges; both counters wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_write_i)     stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (!ifid_flush_n_i) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule
